// File: rtl/exec_datapath_seq.sv
// Sequential execute/datapath stage: one instruction per four cycles (IDLE/READ/EXEC/WB).
// Reads operands from the integer register file, drives the ALU and writes back with registered outputs.
module exec_datapath_seq #(
    parameter int unsigned DW     = 32,
    parameter int unsigned RAW    = 6,
    parameter logic [7:0]  ALU_LO = 8'h10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [31:0]    instr,
    output logic [RAW-1:0] ireg_r0,
    output logic [RAW-1:0] ireg_r1,
    input  logic [DW-1:0]  ireg_d0,
    input  logic [DW-1:0]  ireg_d1,
    output logic [DW-1:0]  alu_d0,
    output logic [DW-1:0]  alu_d1,
    output logic [3:0]     alu_op,
    input  logic [DW-1:0]  alu_dout,
    output logic [RAW-1:0] ireg_rw,
    output logic [DW-1:0]  ireg_dw,
    output logic           ireg_we,
    output logic [DW-1:0]  dr_out,
    output logic           done,
    output logic           illegal
);

    localparam logic [7:0] OpLimm16 = 8'h02;
    localparam logic [7:0] OpCp     = 8'hd2;
    localparam logic [7:0] OpCpdr   = 8'hd3;

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    state_e state_q, state_d;

    logic [31:0]    instr_q;
    logic [DW-1:0]  alu_d0_q, alu_d1_q;
    logic [3:0]     alu_op_q;
    logic [RAW-1:0] rw_q;
    logic [DW-1:0]  dw_q;
    logic           we_q;
    logic           done_q;
    logic [DW-1:0]  dr_q;
    logic           illegal_q;

    // Instruction field decode from the latched instruction.
    logic [7:0]     op;
    logic [RAW-1:0] opd0, opd1, opd2;
    logic [15:0]    imm16;
    logic [DW-1:0]  imm_ext;

    assign op      = instr_q[31:24];
    assign opd0    = instr_q[18 +: RAW];
    assign opd1    = instr_q[12 +: RAW];
    assign opd2    = instr_q[6 +: RAW];
    assign imm16   = instr_q[15:0];
    assign imm_ext = DW'($signed(imm16));

    // Widened subtraction: opcodes below ALU_LO wrap to large values and fall outside the class.
    logic [8:0] alu_rel;
    logic       is_alu, is_limm, is_cp, is_cpdr, is_known, is_write;

    assign alu_rel  = {1'b0, op} - {1'b0, ALU_LO};
    assign is_alu   = (alu_rel < 9'd16);
    assign is_limm  = (op == OpLimm16);
    assign is_cp    = (op == OpCp);
    assign is_cpdr  = (op == OpCpdr);
    assign is_known = is_alu | is_limm | is_cp | is_cpdr;
    assign is_write = is_alu | is_limm | is_cp;

    // Read addresses requested by the current opcode.
    logic [RAW-1:0] rd0_addr, rd1_addr;

    always_comb begin
        rd0_addr = opd1;
        rd1_addr = opd2;
        if (is_limm) begin
            rd0_addr = '0;
            rd1_addr = '0;
        end else if (is_cp || is_cpdr) begin
            rd1_addr = '0;
        end
    end

    // Value written back in WB, selected at the end of EXEC.
    logic [DW-1:0] wb_data;

    always_comb begin
        wb_data = '0;
        if (is_alu) begin
            wb_data = alu_dout;
        end else if (is_limm) begin
            wb_data = imm_ext;
        end else if (is_cp) begin
            wb_data = ireg_d0;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        ireg_r0     = '0;
        ireg_r1     = '0;
        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                ireg_r0 = rd0_addr;
                ireg_r1 = rd1_addr;
                state_d = StExec;
            end
            StExec: begin
                ireg_r0 = rd0_addr;
                ireg_r1 = rd1_addr;
                state_d = StWb;
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && instr_valid) begin
                instr_q <= instr;
            end
        end
    end

    // ALU operands are registered at the end of READ so the ALU result is settled during EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_d0_q <= '0;
            alu_d1_q <= '0;
            alu_op_q <= '0;
        end else if (state_q == StRead && is_alu) begin
            alu_d0_q <= ireg_d0;
            alu_d1_q <= ireg_d1;
            alu_op_q <= op[3:0];
        end
    end

    // Write-back strobes exist only for the single WB cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            rw_q      <= '0;
            dw_q      <= '0;
            dr_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            rw_q   <= '0;
            dw_q   <= '0;
            if (state_q == StExec) begin
                done_q <= 1'b1;
                we_q   <= is_write;
                rw_q   <= opd0;
                dw_q   <= is_write ? wb_data : '0;
                if (is_cpdr) begin
                    dr_q <= ireg_d0;
                end
                if (!is_known) begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    assign alu_d0  = alu_d0_q;
    assign alu_d1  = alu_d1_q;
    assign alu_op  = alu_op_q;
    assign ireg_rw = rw_q;
    assign ireg_dw = dw_q;
    assign ireg_we = we_q;
    assign done    = done_q;
    assign dr_out  = dr_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_exec_datapath_seq.sv
// Directed bench for exec_datapath_seq with a register-file/ALU environment model and a
// write-back scoreboard queue.
module tb_exec_datapath_seq;

    localparam int unsigned DW  = 32;
    localparam int unsigned RAW = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic           instr_valid;
    logic           instr_ready;
    logic [31:0]    instr;
    logic [RAW-1:0] ireg_r0, ireg_r1, ireg_rw;
    logic [DW-1:0]  ireg_d0, ireg_d1, alu_d0, alu_d1, alu_dout, ireg_dw, dr_out;
    logic [3:0]     alu_op;
    logic           ireg_we, done, illegal;

    exec_datapath_seq #(.DW(DW), .RAW(RAW), .ALU_LO(8'h10)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ireg_r0     (ireg_r0),
        .ireg_r1     (ireg_r1),
        .ireg_d0     (ireg_d0),
        .ireg_d1     (ireg_d1),
        .alu_d0      (alu_d0),
        .alu_d1      (alu_d1),
        .alu_op      (alu_op),
        .alu_dout    (alu_dout),
        .ireg_rw     (ireg_rw),
        .ireg_dw     (ireg_dw),
        .ireg_we     (ireg_we),
        .dr_out      (dr_out),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Register file model with a bench-side preload port.
    logic [DW-1:0]  regs [64];
    logic           pl_we = 1'b0;
    logic [RAW-1:0] pl_addr = '0;
    logic [DW-1:0]  pl_data = '0;

    always @(posedge clk) begin
        if (ireg_we) regs[ireg_rw] <= ireg_dw;
        else if (pl_we) regs[pl_addr] <= pl_data;
    end

    assign ireg_d0 = regs[ireg_r0];
    assign ireg_d1 = regs[ireg_r1];

    // ALU model: 4 = add, 5 = sub, everything else xor.
    always_comb begin
        alu_dout = alu_d0 ^ alu_d1;
        if (alu_op == 4'd4) alu_dout = alu_d0 + alu_d1;
        else if (alu_op == 4'd5) alu_dout = alu_d0 - alu_d1;
    end

    typedef struct {
        logic           we;
        logic [RAW-1:0] rw;
        logic [DW-1:0]  dw;
        logic [DW-1:0]  dr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic [DW-1:0] exp_dr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [5:0] d0,
                                       input logic [5:0] d1, input logic [5:0] d2);
        return {op, d0, d1, d2, 6'd0};
    endfunction

    function automatic logic [31:0] mk_limm(input logic [5:0] d0, input logic [15:0] imm);
        return {8'h02, d0, 2'b00, imm};
    endfunction

    task automatic preload(input logic [RAW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Called at a WB negedge; compares the retiring instruction against the queue head.
    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_we"}, 64'(ireg_we), 64'(e.we));
        if (e.we) begin
            chk({tag, "_rw"}, 64'(ireg_rw), 64'(e.rw));
            chk({tag, "_dw"}, 64'(ireg_dw), 64'(e.dw));
        end
        chk({tag, "_dr"}, 64'(dr_out), 64'(e.dr));
    endtask

    // Issues one instruction from IDLE and waits (bounded) for it to retire.
    task automatic issue(input string tag, input logic [31:0] ins, input exp_t e);
        int lat;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(instr_ready), 64'd1);
        chk({tag, "_idle_we"}, 64'(ireg_we), 64'd0);
        sb.push_back(e);
        instr = ins; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0; instr = $urandom;
        lat = 1;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd3);
        pop_check(tag);
    endtask

    initial begin
        exp_t e;
        logic [15:0] imm;
        logic saw;
        for (int i = 0; i < 64; i++) regs[i] = '0;
        instr = '0; instr_valid = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(instr_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_we", 64'(ireg_we), 64'd0);
        chk("rst_dr", 64'(dr_out), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        reset = 1'b0;

        // LIMM16 sign extension
        e = '{we: 1'b1, rw: 6'd5, dw: 32'hFFFFFFFE, dr: exp_dr};
        issue("limm", mk_limm(6'd5, 16'hFFFE), e);

        // ADD then SUB back to back
        preload(6'd1, 32'd7);
        preload(6'd2, 32'd3);
        e = '{we: 1'b1, rw: 6'd3, dw: 32'd10, dr: exp_dr};
        issue("add", mk(8'h14, 6'd3, 6'd1, 6'd2), e);
        chk("add_alu_op", 64'(alu_op), 64'd4);
        e = '{we: 1'b1, rw: 6'd4, dw: 32'd4, dr: exp_dr};
        issue("sub", mk(8'h15, 6'd4, 6'd1, 6'd2), e);
        chk("sub_alu_op", 64'(alu_op), 64'd5);
        @(negedge clk);
        chk("r3_val", 64'(regs[3]), 64'd10);
        chk("r4_val", 64'(regs[4]), 64'd4);
        chk("r5_val", 64'(regs[5]), 64'hFFFFFFFE);

        // CPDR into the data register, no write-back
        preload(6'd1, 32'h80000000);
        exp_dr = 32'h80000000;
        e = '{we: 1'b0, rw: 6'd0, dw: 32'd0, dr: exp_dr};
        issue("cpdr", mk(8'hd3, 6'd0, 6'd1, 6'd0), e);

        // CP and ALU class boundaries (xor in the model)
        e = '{we: 1'b1, rw: 6'd6, dw: 32'd3, dr: exp_dr};
        issue("cp", mk(8'hd2, 6'd6, 6'd2, 6'd9), e);
        e = '{we: 1'b1, rw: 6'd7, dw: 32'h80000003, dr: exp_dr};
        issue("alu_lo", mk(8'h10, 6'd7, 6'd1, 6'd2), e);
        chk("alu_lo_op", 64'(alu_op), 64'd0);
        e = '{we: 1'b1, rw: 6'd8, dw: 32'h80000003, dr: exp_dr};
        issue("alu_hi", mk(8'h1F, 6'd8, 6'd1, 6'd2), e);
        chk("alu_hi_op", 64'(alu_op), 64'hF);
        @(negedge clk);
        chk("legal_no_illegal", 64'(illegal), 64'd0);

        // Unknown opcode: retire without write, illegal becomes sticky
        e = '{we: 1'b0, rw: 6'd0, dw: 32'd0, dr: exp_dr};
        issue("unk", mk(8'hFF, 6'd10, 6'd1, 6'd2), e);
        @(negedge clk);
        chk("unk_illegal", 64'(illegal), 64'd1);
        chk("unk_r10", 64'(regs[10]), 64'd0);
        e = '{we: 1'b1, rw: 6'd9, dw: 32'h00001234, dr: exp_dr};
        issue("after_unk", mk_limm(6'd9, 16'h1234), e);
        chk("illegal_sticky", 64'(illegal), 64'd1);

        // instr_valid held high with a new instruction every cycle
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (done) pop_check("stream");
            chk("stream_ready", 64'(instr_ready), 64'((i % 4) == 0));
            imm = (i % 2 == 1) ? (16'h8000 | 16'(i)) : 16'(i * 257 + 1);
            instr = mk_limm(6'(20 + i), imm);
            instr_valid = 1'b1;
            if (i % 4 == 0) begin
                e = '{we: 1'b1, rw: 6'(20 + i), dw: {{16{imm[15]}}, imm}, dr: exp_dr};
                sb.push_back(e);
            end
        end
        @(negedge clk);
        instr_valid = 1'b0;
        chk("stream_sb_drained", 64'(sb.size()), 64'd0);
        chk("stream_r21_untouched", 64'(regs[21]), 64'd0);
        chk("stream_illegal", 64'(illegal), 64'd1);

        // Reset held two cycles during EXEC of an ADD aborts it
        preload(6'd3, 32'h55);
        @(negedge clk);
        instr = mk(8'h14, 6'd3, 6'd1, 6'd2); instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_we", 64'(ireg_we), 64'd0);
        chk("abort_ready", 64'(instr_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_dr", 64'(dr_out), 64'd0);
        chk("abort_illegal", 64'(illegal), 64'd0);
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || ireg_we) saw = 1'b1;
        end
        chk("abort_no_retire", 64'(saw), 64'd0);
        chk("abort_r3", 64'(regs[3]), 64'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
